// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the sync_fifo block.
package sync_fifo_pkg;

  localparam int unsigned DefaultAddrWidth = 2;
  localparam int unsigned DefaultDataWidth = 16;

  // Number of storage entries for a given pointer width.
  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Pointers carry one extra wrap bit above the storage index.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one synchronous write port and one registered read port.
// The array itself is never reset; only the read data register is.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned Depth = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [Depth];

  // Write port; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; a same-edge write to raddr returns the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered (non fall-through) reads and full/empty flags.
// Optional macro SYNC_FIFO_ERR_FLAGS_EN adds wr_overflow / rd_underflow pulse outputs.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  wr_overflow,
  output logic                  rd_underflow
`endif
);

  localparam int unsigned PtrWidth = ptr_width(ADDR_WIDTH);

  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic                wr_ok;
  logic                rd_ok;

  // Flags come straight from the registered pointers.
  always_comb begin
    rd_empty = (wr_ptr_q == rd_ptr_q);
    wr_full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
               (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  end

  // Acceptance and pointer next-state; a read frees a slot for a same-cycle write when full.
  always_comb begin
    rd_ok    = rd_en && !rd_empty;
    wr_ok    = wr_en && (!wr_full || rd_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PtrWidth'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PtrWidth'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  sync_fifo_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   (wr_ok),
    .waddr(wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata(wr_data),
    .re   (rd_ok),
    .raddr(rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata(rd_data)
  );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // One-cycle pulses flagging a dropped write or a read of an empty FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      wr_overflow  <= wr_en && wr_full && !rd_ok;
      rd_underflow <= rd_en && rd_empty;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized scoreboard bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 16;
  localparam int          DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          wr_full;
  logic          rd_empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          wr_overflow;
  logic          rd_underflow;
`endif

  always #5 clk = ~clk;

  sync_fifo #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .wr_full (wr_full),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_empty(rd_empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .wr_overflow (wr_overflow),
    .rd_underflow(rd_underflow)
`endif
  );

  // Reference model: contents as a plain queue, plus expected read results.
  logic [DW-1:0] model[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rd = '0;
  bit            exp_ovf = 1'b0;
  bit            exp_unf = 1'b0;
  bit            started = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Drive one cycle; at the edge, apply the FIFO rules to the model.
  task automatic step(input bit rst, input bit we, input bit re, input logic [DW-1:0] d);
    bit rok;
    bit wok;
    reset   = rst;
    wr_en   = we;
    rd_en   = re;
    wr_data = d;
    @(posedge clk);
    if (rst) begin
      model.delete();
      exp_q.delete();
      exp_q.push_back('0);
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      started = 1'b1;
    end else begin
      rok     = re && (model.size() > 0);
      wok     = we && ((model.size() < DEPTH) || rok);
      exp_ovf = we && (model.size() == DEPTH) && !rok;
      exp_unf = re && (model.size() == 0);
      if (rok) exp_q.push_back(model.pop_front());
      if (wok) model.push_back(d);
    end
    @(negedge clk);
  endtask

  // Monitor: mid-cycle comparison of outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      if (exp_q.size() > 0) exp_rd = exp_q.pop_front();
      check("rd_data", 32'(rd_data), 32'(exp_rd));
      check("rd_empty", 32'(rd_empty), 32'(model.size() == 0));
      check("wr_full", 32'(wr_full), 32'(model.size() == DEPTH));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      check("wr_overflow", 32'(wr_overflow), 32'(exp_ovf));
      check("rd_underflow", 32'(rd_underflow), 32'(exp_unf));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    // Reset for two edges.
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);

    // Fill and drain.
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, '0);

    // Overflow: fifth write dropped, then drain.
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, DW'(i * 10));
    step(1'b0, 1'b1, 1'b0, DW'(99));
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, '0);

    // Underflow: reads while empty leave rd_data alone.
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);

    // Full with simultaneous read and write.
    for (int i = 5; i <= 8; i++) step(1'b0, 1'b1, 1'b0, DW'(i));
    step(1'b0, 1'b1, 1'b1, DW'(9));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, '0);

    // Simultaneous read and write when empty: only the write lands.
    step(1'b0, 1'b1, 1'b1, DW'(16'h77));
    step(1'b0, 1'b0, 1'b1, '0);

    // Wrap-around: 12 values streamed with interleaved reads.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, (i >= 2), DW'(100 + i));
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);

    // Mid-operation reset with 3 entries stored.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, DW'(200 + i));
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, DW'(16'h55));
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           DW'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
